// File: rtl/mips_mem_bridge.sv
// rtl/mips_mem_bridge.sv - multicycle MIPS memory-access stage driving a wait-stated bus
//
// Purpose: turns the control unit's MemRead/MemWrite/IorD/IrWrite strobes into
// a single held bus request, stalls the state register while the access is
// outstanding, and captures read data into IR or MDR.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   mem_read, mem_write            access strobes from the control unit
//   iord                           address select: 0 = pc, 1 = alu_out
//   ir_write                       read destination: 1 = ir, 0 = mdr
//   pc, alu_out, wdata             address sources and store data
//   stall                          hold state register / PC this cycle
//   ir, mdr                        instruction and memory data registers
//   err                            sticky fault (timeout or read+write conflict)
//   bus_req, bus_we                request (held until ack) and write flag
//   bus_addr, bus_wdata            latched address and store data
//   bus_rdata, bus_ack             read data and one-cycle completion pulse

module mips_mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              iord,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Last REQ cycle index that may still be acked before declaring a timeout.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tmo_cnt;
    logic       dst;
    logic       start;
    logic       capture;
    logic       cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        bus_req   = 1'b0;
        err       = 1'b0;
        start     = 1'b0;
        capture   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                stall = mem_read | mem_write;
                if (mem_read & mem_write) begin
                    state_nxt = S_ERR;
                end else if (mem_read ^ mem_write) begin
                    start     = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_ack) begin
                    capture   = ~bus_we;
                    state_nxt = S_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_ERR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            // Strobes still high here belong to the access just finished.
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                stall = 1'b1;
                err   = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_wdata <= '0;
            dst       <= 1'b0;
            tmo_cnt   <= 8'd0;
        end else if (start) begin
            bus_addr  <= iord ? alu_out : pc;
            bus_we    <= mem_write;
            bus_wdata <= wdata;
            dst       <= ir_write;
            tmo_cnt   <= 8'd0;
        end else if (cnt_inc) begin
            tmo_cnt   <= tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir  <= '0;
            mdr <= '0;
        end else if (capture) begin
            if (dst) begin
                ir <= bus_rdata;
            end else begin
                mdr <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_bridge.sv
// tb/tb_mips_mem_bridge.sv - self-checking bench for mips_mem_bridge

module tb_mips_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        iord = 1'b0;
    logic        ir_write = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    always #5 clk = ~clk;

    mips_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .stall(stall), .ir(ir), .mdr(mdr), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    typedef struct {
        logic        wr;
        logic        iord;
        logic        irw;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] rd;
        int          waits;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] mdr;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] m_ir = '0;
    logic [31:0] m_mdr = '0;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ir_mdr(input string tag);
        sb_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ir"}, ir, e.ir);
            chk({tag, "_mdr"}, mdr, e.mdr);
        end
    endtask

    task automatic drop_strobes();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = 1'b0;
    endtask

    // Called away from a rising edge; leaves the bench just after a falling edge.
    task automatic do_reset();
        drop_strobes();
        rst_n = 1'b0;
        m_ir  = '0;
        m_mdr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_access(input vec_t v);
        sb_t e;
        @(posedge clk); #1;
        mem_read  = ~v.wr;
        mem_write = v.wr;
        iord      = v.iord;
        ir_write  = v.irw;
        pc        = v.pc;
        alu_out   = v.alu;
        wdata     = v.wd;
        if (!v.wr) begin
            if (v.irw) m_ir = v.rd;
            else       m_mdr = v.rd;
        end
        e.ir  = m_ir;
        e.mdr = m_mdr;
        sb.push_back(e);
        @(negedge clk);
        chk("idle_stall", {31'd0, stall}, 32'd1);
        chk("idle_req", {31'd0, bus_req}, 32'd0);
        for (int k = 0; k <= v.waits; k++) begin
            @(posedge clk); #1;
            bus_ack   = (k == v.waits);
            bus_rdata = (k == v.waits) ? v.rd : ~v.rd;
            @(negedge clk);
            chk("req_req", {31'd0, bus_req}, 32'd1);
            chk("req_stall", {31'd0, stall}, 32'd1);
            chk("req_addr", bus_addr, v.exp_addr);
            chk("req_we", {31'd0, bus_we}, {31'd0, v.wr});
            chk("req_wdata", bus_wdata, v.wd);
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_req", {31'd0, bus_req}, 32'd0);
        chk("done_err", {31'd0, err}, 32'd0);
        chk_ir_mdr("done");
        @(posedge clk); #1;
        drop_strobes();
        @(negedge clk);
        chk("after_req", {31'd0, bus_req}, 32'd0);
        chk("after_stall", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h40, 32'h0,   32'h0,    32'h8C010004, 0, 32'h40};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0,    32'hDEADBEEF, 3, 32'h100};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h48, 32'h200, 32'h1234, 32'h55AA55AA, 1, 32'h200};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h4C, 32'h300, 32'h0,    32'h01234567, 2, 32'h4C};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h50, 32'h304, 32'h0,    32'hCAFEF00D, 0, 32'h304};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h54, 32'h308, 32'hA5A5, 32'h0F0F0F0F, 0, 32'h54};

        #2;
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_mdr", mdr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        do_reset();

        // Stray ack in IDLE must be ignored.
        @(posedge clk); #1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_req", {31'd0, bus_req}, 32'd0);
        chk("stray_stall", {31'd0, stall}, 32'd0);
        chk("stray_ir", ir, 32'd0);
        chk("stray_mdr", mdr, 32'd0);

        foreach (vecs[i]) run_access(vecs[i]);

        // Timeout: 4 REQ cycles without ack, then sticky ERR.
        @(posedge clk); #1;
        mem_read = 1'b1;
        iord     = 1'b1;
        alu_out  = 32'h400;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("tmo_req", {31'd0, bus_req}, 32'd1);
            chk("tmo_err_pending", {31'd0, err}, 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus_ack   = 1'b1;
            bus_rdata = 32'h77777777;
            @(negedge clk);
            chk("tmo_err", {31'd0, err}, 32'd1);
            chk("tmo_req_off", {31'd0, bus_req}, 32'd0);
            chk("tmo_stall", {31'd0, stall}, 32'd1);
        end
        chk("tmo_mdr", mdr, m_mdr);
        chk("tmo_ir", ir, m_ir);
        do_reset();
        chk("tmo_rst_err", {31'd0, err}, 32'd0);
        chk("tmo_rst_stall", {31'd0, stall}, 32'd0);

        // Read+write conflict goes straight to ERR.
        @(posedge clk); #1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        @(negedge clk);
        chk("conf_idle_stall", {31'd0, stall}, 32'd1);
        chk("conf_idle_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        drop_strobes();
        @(negedge clk);
        chk("conf_err", {31'd0, err}, 32'd1);
        chk("conf_req", {31'd0, bus_req}, 32'd0);
        chk("conf_stall", {31'd0, stall}, 32'd1);
        do_reset();

        // Reset asserted mid-access drops bus_req at once.
        @(posedge clk); #1;
        mem_read = 1'b1;
        iord     = 1'b0;
        pc       = 32'h80;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_before", {31'd0, bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        drop_strobes();
        #1;
        chk("mid_req", {31'd0, bus_req}, 32'd0);
        chk("mid_addr", bus_addr, 32'd0);
        chk("mid_ir", ir, 32'd0);
        chk("mid_mdr", mdr, 32'd0);
        chk("mid_stall", {31'd0, stall}, 32'd0);
        m_ir  = '0;
        m_mdr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_idle_req", {31'd0, bus_req}, 32'd0);
        chk("mid_idle_err", {31'd0, err}, 32'd0);
        run_access(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
